// File: rtl/tcam_access_ctrl_if.sv
// Bus bundle for tcam_access_ctrl: the write and search request channels, the result channel,
// the memory-wrapper port and the debug taps.
interface tcam_access_ctrl_if #(
   parameter int KEY_W     = 28,
   parameter int WR_ADDR_W = 10,
   parameter int DATA_W    = 32,
   parameter int WMASK_W   = 4,
   parameter int PMA_W     = 6
);
   // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high.
   // Ready never depends on the previous transfer's data. A producer may drop valid without a
   // transfer, and that has no effect. Request fields are sampled only in the transfer cycle.
   logic                 in_wr_valid;
   logic [WR_ADDR_W-1:0] in_wr_addr;
   logic [WMASK_W-1:0]   in_wr_wmask;
   logic [DATA_W-1:0]    in_wr_wdata;
   logic                 out_wr_ready;

   logic                 in_srch_valid;
   logic [KEY_W-1:0]     in_srch_key;
   logic                 out_srch_ready;

   logic                 out_res_valid;
   logic [PMA_W-1:0]     out_res_pma;
   logic                 in_res_ready;

   logic                 out_mem_csb;
   logic                 out_mem_web;
   logic [WMASK_W-1:0]   out_mem_wmask;
   logic [KEY_W-1:0]     out_mem_addr;
   logic [DATA_W-1:0]    out_mem_wdata;
   logic [PMA_W-1:0]     in_mem_pma;

   logic                 out_busy;
   logic [2:0]           dbg_state;
   logic [7:0]           dbg_wr_streak;

   modport slave (
      input  in_wr_valid, in_wr_addr, in_wr_wmask, in_wr_wdata,
      input  in_srch_valid, in_srch_key, in_res_ready, in_mem_pma,
      output out_wr_ready, out_srch_ready, out_res_valid, out_res_pma,
      output out_mem_csb, out_mem_web, out_mem_wmask, out_mem_addr, out_mem_wdata,
      output out_busy, dbg_state, dbg_wr_streak
   );

   modport master (
      output in_wr_valid, in_wr_addr, in_wr_wmask, in_wr_wdata,
      output in_srch_valid, in_srch_key, in_res_ready, in_mem_pma,
      input  out_wr_ready, out_srch_ready, out_res_valid, out_res_pma,
      input  out_mem_csb, out_mem_web, out_mem_wmask, out_mem_addr, out_mem_wdata,
      input  out_busy, dbg_state, dbg_wr_streak
   );
endinterface

// File: rtl/tcam_access_ctrl.sv
// Arbitrates rule writes and key searches onto the single TCAM wrapper port and buffers one
// search result behind a valid/ready handshake.
module tcam_access_ctrl #(
   parameter int KEY_W        = 28,
   parameter int WR_ADDR_W    = 10,
   parameter int DATA_W       = 32,
   parameter int WMASK_W      = 4,
   parameter int PMA_W        = 6,
   parameter int RD_LAT       = 1,
   parameter int MAX_WR_BURST = 4
) (
   input  logic               in_clk,
   input  logic               in_rstn,
   tcam_access_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      SEARCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int STREAK_W = $clog2(MAX_WR_BURST + 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(RD_LAT - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_BURST);

   state_t               state;
   logic [STREAK_W-1:0]  wr_streak;
   logic [CNT_W-1:0]     lat_cnt;
   logic                 mem_csb;
   logic                 mem_web;
   logic [WMASK_W-1:0]   mem_wmask;
   logic [KEY_W-1:0]     mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 res_valid;
   logic [PMA_W-1:0]     res_pma;

   logic is_idle;
   logic grant_wr;
   logic grant_srch;

   // Writes win unless a search has already waited out a full write burst.
   always_comb begin
      is_idle    = (state == IDLE);
      grant_wr   = bus.in_wr_valid & (~bus.in_srch_valid | (wr_streak < STREAK_MAX));
      grant_srch = bus.in_srch_valid & ~grant_wr;
   end

   assign bus.out_wr_ready   = is_idle & grant_wr;
   assign bus.out_srch_ready = is_idle & grant_srch;
   assign bus.out_res_valid  = res_valid;
   assign bus.out_res_pma    = res_pma;
   assign bus.out_mem_csb    = mem_csb;
   assign bus.out_mem_web    = mem_web;
   assign bus.out_mem_wmask  = mem_wmask;
   assign bus.out_mem_addr   = mem_addr;
   assign bus.out_mem_wdata  = mem_wdata;
   assign bus.out_busy       = ~is_idle;
   assign bus.dbg_state      = state;
   assign bus.dbg_wr_streak  = 8'(wr_streak);

   always_ff @(posedge in_clk or negedge in_rstn) begin
      if (!in_rstn) begin
         state     <= IDLE;
         wr_streak <= '0;
         lat_cnt   <= '0;
         mem_csb   <= 1'b1;
         mem_web   <= 1'b1;
         mem_wmask <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         res_valid <= 1'b0;
         res_pma   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  state     <= WRITE;
                  mem_csb   <= 1'b0;
                  mem_web   <= 1'b0;
                  mem_addr  <= KEY_W'(bus.in_wr_addr);
                  mem_wmask <= bus.in_wr_wmask;
                  mem_wdata <= bus.in_wr_wdata;
                  if (bus.in_srch_valid && (wr_streak != STREAK_MAX))
                     wr_streak <= wr_streak + 1'b1;
               end else if (grant_srch) begin
                  state     <= SEARCH;
                  mem_csb   <= 1'b0;
                  mem_web   <= 1'b1;
                  mem_addr  <= bus.in_srch_key;
                  mem_wmask <= '0;
                  mem_wdata <= '0;
                  wr_streak <= '0;
               end
            end
            WRITE: begin
               state     <= IDLE;
               mem_csb   <= 1'b1;
               mem_web   <= 1'b1;
               mem_wmask <= '0;
            end
            SEARCH: begin
               state   <= WAIT;
               mem_csb <= 1'b1;
               lat_cnt <= CNT_LOAD;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  res_pma   <= bus.in_mem_pma;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RESP: begin
               // Draining the result returns to IDLE first, so no grant shares this cycle.
               if (bus.in_res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tcam_access_ctrl.sv
// Bench for tcam_access_ctrl: directed scenarios plus a randomized run against a
// cycle-budget reference model of the arbiter and a latency-accurate TCAM model.
module tb_tcam_access_ctrl;
   localparam int KEY_W = 28, WR_ADDR_W = 10, DATA_W = 32, WMASK_W = 4, PMA_W = 6;
   localparam int RD_LAT = 1, MAX_WR_BURST = 4;
   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd3;

   logic in_clk  = 1'b0;
   logic in_rstn = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   always #5 in_clk = ~in_clk;

   tcam_access_ctrl_if #(.KEY_W(KEY_W), .WR_ADDR_W(WR_ADDR_W), .DATA_W(DATA_W),
                         .WMASK_W(WMASK_W), .PMA_W(PMA_W)) bus ();

   tcam_access_ctrl #(.KEY_W(KEY_W), .WR_ADDR_W(WR_ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W),
                      .PMA_W(PMA_W), .RD_LAT(RD_LAT), .MAX_WR_BURST(MAX_WR_BURST)) dut (
      .in_clk  (in_clk),
      .in_rstn (in_rstn),
      .bus     (bus)
   );

   // TCAM model: the match for a read strobe is stable for exactly one cycle, RD_LAT edges later.
   function automatic logic [PMA_W-1:0] pma_of(input logic [KEY_W-1:0] key);
      if (key == 28'h0ABCDEF) return 6'd37;
      return key[5:0] ^ key[17:12] ^ key[27:22];
   endfunction

   logic [PMA_W:0]   pma_pipe [RD_LAT];
   logic [PMA_W-1:0] junk;

   always @(posedge in_clk) begin
      pma_pipe[0] <= (!bus.out_mem_csb && bus.out_mem_web) ? {1'b1, pma_of(bus.out_mem_addr)} : '0;
      for (int i = 1; i < RD_LAT; i++) pma_pipe[i] <= pma_pipe[i-1];
      junk <= PMA_W'($urandom);
   end

   assign bus.in_mem_pma = pma_pipe[RD_LAT-1][PMA_W] ? pma_pipe[RD_LAT-1][PMA_W-1:0] : junk;

   task automatic cyc();
      @(posedge in_clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_wr_valid   = 1'b0;
      bus.in_wr_addr    = '0;
      bus.in_wr_wmask   = '0;
      bus.in_wr_wdata   = '0;
      bus.in_srch_valid = 1'b0;
      bus.in_srch_key   = '0;
      bus.in_res_ready  = 1'b0;
   endtask

   task automatic test_reset();
      in_rstn = 1'b0;
      idle_inputs();
      repeat (3) cyc();
      total++; if (bus.out_mem_csb !== 1'b1) begin bad++; $display("FAIL reset_csb got=%0b exp=1", bus.out_mem_csb); end
      total++; if (bus.out_mem_web !== 1'b1) begin bad++; $display("FAIL reset_web got=%0b exp=1", bus.out_mem_web); end
      total++; if (bus.out_mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.out_mem_addr); end
      total++; if (bus.out_res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b exp=0", bus.out_res_valid); end
      total++; if (bus.out_res_pma !== '0) begin bad++; $display("FAIL reset_res_pma got=%0d exp=0", bus.out_res_pma); end
      total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.out_busy); end
      in_rstn = 1'b1;
      cyc();
      total++; if (bus.out_busy !== 1'b0 || bus.out_mem_csb !== 1'b1) begin bad++; $display("FAIL idle_after_reset busy=%0b csb=%0b exp busy=0 csb=1", bus.out_busy, bus.out_mem_csb); end
      total++; if (bus.out_wr_ready !== 1'b0 || bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL idle_ready wr=%0b srch=%0b exp 0 0", bus.out_wr_ready, bus.out_srch_ready); end
   endtask

   task automatic test_single_write();
      idle_inputs();
      bus.in_wr_valid = 1'b1;
      bus.in_wr_addr  = 10'h2A5;
      bus.in_wr_wmask = 4'hF;
      bus.in_wr_wdata = 32'hDEADBEEF;
      #1;
      total++; if (bus.out_wr_ready !== 1'b1) begin bad++; $display("FAIL wr_accept got=%0b exp=1", bus.out_wr_ready); end
      cyc();
      // Next request carries a zero byte mask and different fields.
      bus.in_wr_addr  = 10'h155;
      bus.in_wr_wmask = 4'h0;
      bus.in_wr_wdata = 32'h12345678;
      total++; if (bus.out_mem_csb !== 1'b0 || bus.out_mem_web !== 1'b0) begin bad++; $display("FAIL wr_strobe csb=%0b web=%0b exp 0 0", bus.out_mem_csb, bus.out_mem_web); end
      total++; if (bus.out_mem_addr !== 28'h00002A5) begin bad++; $display("FAIL wr_addr got=%0h exp=2a5", bus.out_mem_addr); end
      total++; if (bus.out_mem_wmask !== 4'hF) begin bad++; $display("FAIL wr_wmask got=%0h exp=f", bus.out_mem_wmask); end
      total++; if (bus.out_mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%0h exp=deadbeef", bus.out_mem_wdata); end
      total++; if (bus.out_wr_ready !== 1'b0 || bus.out_busy !== 1'b1) begin bad++; $display("FAIL wr_busy ready=%0b busy=%0b exp 0 1", bus.out_wr_ready, bus.out_busy); end
      cyc();
      total++; if (bus.out_mem_csb !== 1'b1 || bus.out_mem_web !== 1'b1 || bus.out_mem_wmask !== 4'h0) begin bad++; $display("FAIL wr_release csb=%0b web=%0b wmask=%0h exp 1 1 0", bus.out_mem_csb, bus.out_mem_web, bus.out_mem_wmask); end
      total++; if (bus.out_mem_addr !== 28'h00002A5 || bus.out_mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_hold addr=%0h wdata=%0h exp 2a5 deadbeef", bus.out_mem_addr, bus.out_mem_wdata); end
      total++; if (bus.out_wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_again got=%0b exp=1", bus.out_wr_ready); end
      cyc();
      bus.in_wr_valid = 1'b0;
      total++; if (bus.out_mem_csb !== 1'b0 || bus.out_mem_wmask !== 4'h0 || bus.out_mem_addr !== 28'h0000155) begin bad++; $display("FAIL wr_zero_mask csb=%0b wmask=%0h addr=%0h exp 0 0 155", bus.out_mem_csb, bus.out_mem_wmask, bus.out_mem_addr); end
      cyc();
      total++; if (bus.out_busy !== 1'b0 || bus.out_mem_csb !== 1'b1) begin bad++; $display("FAIL wr_done busy=%0b csb=%0b exp 0 1", bus.out_busy, bus.out_mem_csb); end
   endtask

   task automatic test_search();
      idle_inputs();
      bus.in_srch_valid = 1'b1;
      bus.in_srch_key   = 28'h0ABCDEF;
      #1;
      total++; if (bus.out_srch_ready !== 1'b1) begin bad++; $display("FAIL srch_accept got=%0b exp=1", bus.out_srch_ready); end
      cyc();
      bus.in_srch_key = 28'h1234567;
      total++; if (bus.out_mem_csb !== 1'b0 || bus.out_mem_web !== 1'b1) begin bad++; $display("FAIL srch_strobe csb=%0b web=%0b exp 0 1", bus.out_mem_csb, bus.out_mem_web); end
      total++; if (bus.out_mem_addr !== 28'h0ABCDEF || bus.out_mem_wmask !== 4'h0 || bus.out_mem_wdata !== '0) begin bad++; $display("FAIL srch_fields addr=%0h wmask=%0h wdata=%0h exp abcdef 0 0", bus.out_mem_addr, bus.out_mem_wmask, bus.out_mem_wdata); end
      total++; if (bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL srch_busy_ready got=%0b exp=0", bus.out_srch_ready); end
      cyc();
      total++; if (bus.out_mem_csb !== 1'b1 || bus.out_res_valid !== 1'b0 || bus.dbg_state !== S_WAIT) begin bad++; $display("FAIL srch_wait csb=%0b res_valid=%0b state=%0d exp 1 0 %0d", bus.out_mem_csb, bus.out_res_valid, bus.dbg_state, S_WAIT); end
      cyc();
      total++; if (bus.out_res_valid !== 1'b1 || bus.out_res_pma !== 6'd37) begin bad++; $display("FAIL srch_result valid=%0b pma=%0d exp 1 37", bus.out_res_valid, bus.out_res_pma); end
      bus.in_res_ready  = 1'b1;
      #1;
      total++; if (bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL srch_resp_no_grant got=%0b exp=0", bus.out_srch_ready); end
      bus.in_srch_valid = 1'b0;
      cyc();
      total++; if (bus.out_res_valid !== 1'b0 || bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL srch_drain valid=%0b state=%0d exp 0 0", bus.out_res_valid, bus.dbg_state); end
   endtask

   task automatic test_backpressure();
      logic [PMA_W-1:0] held;
      idle_inputs();
      bus.in_srch_valid = 1'b1;
      bus.in_srch_key   = 28'h5555AAA;
      cyc();
      bus.in_srch_key = 28'h0F0F0F0;
      for (int k = 0; k < 20 && bus.out_res_valid !== 1'b1; k++) cyc();
      total++; if (bus.out_res_valid !== 1'b1 || bus.out_res_pma !== pma_of(28'h5555AAA)) begin bad++; $display("FAIL bp_first valid=%0b pma=%0d exp 1 %0d", bus.out_res_valid, bus.out_res_pma, pma_of(28'h5555AAA)); end
      held = pma_of(28'h5555AAA);
      for (int k = 0; k < 5; k++) begin
         cyc();
         total++; if (bus.out_res_valid !== 1'b1 || bus.out_res_pma !== held || bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL bp_hold cycle=%0d valid=%0b pma=%0d srch_ready=%0b exp 1 %0d 0", k, bus.out_res_valid, bus.out_res_pma, bus.out_srch_ready, held); end
      end
      bus.in_res_ready = 1'b1;
      cyc();
      total++; if (bus.dbg_state !== S_IDLE || bus.out_res_valid !== 1'b0 || bus.out_srch_ready !== 1'b1) begin bad++; $display("FAIL bp_release state=%0d valid=%0b srch_ready=%0b exp 0 0 1", bus.dbg_state, bus.out_res_valid, bus.out_srch_ready); end
      cyc();
      bus.in_srch_valid = 1'b0;
      total++; if (bus.out_mem_csb !== 1'b0 || bus.out_mem_addr !== 28'h0F0F0F0) begin bad++; $display("FAIL bp_next_search csb=%0b addr=%0h exp 0 f0f0f0", bus.out_mem_csb, bus.out_mem_addr); end
      for (int k = 0; k < 20 && bus.out_res_valid !== 1'b1; k++) cyc();
      total++; if (bus.out_res_pma !== pma_of(28'h0F0F0F0) || bus.out_res_valid !== 1'b1) begin bad++; $display("FAIL bp_second valid=%0b pma=%0d exp 1 %0d", bus.out_res_valid, bus.out_res_pma, pma_of(28'h0F0F0F0)); end
      cyc();
      bus.in_res_ready = 1'b0;
   endtask

   task automatic test_starvation();
      int  grants;
      bit  was_srch;
      bit  exp_srch;
      idle_inputs();
      bus.in_res_ready  = 1'b1;
      bus.in_wr_valid   = 1'b1;
      bus.in_srch_valid = 1'b1;
      grants   = 0;
      was_srch = 1'b0;
      for (int c = 0; c < 300 && grants < 10; c++) begin
         bus.in_wr_addr  = WR_ADDR_W'($urandom);
         bus.in_wr_wmask = WMASK_W'($urandom);
         bus.in_wr_wdata = $urandom;
         bus.in_srch_key = KEY_W'($urandom);
         #1;
         if (was_srch) begin
            total++; if (bus.dbg_wr_streak !== 8'd0) begin bad++; $display("FAIL starve_streak_clear got=%0d exp=0", bus.dbg_wr_streak); end
            was_srch = 1'b0;
         end
         if (bus.out_wr_ready === 1'b1 || bus.out_srch_ready === 1'b1) begin
            exp_srch = (grants % (MAX_WR_BURST + 1)) == MAX_WR_BURST;
            total++; if (bus.out_srch_ready !== exp_srch || bus.out_wr_ready !== !exp_srch) begin bad++; $display("FAIL starve_order grant=%0d wr=%0b srch=%0b exp srch=%0b", grants, bus.out_wr_ready, bus.out_srch_ready, exp_srch); end
            was_srch = bus.out_srch_ready;
            grants++;
         end
         @(posedge in_clk);
         #1;
      end
      total++; if (grants != 10) begin bad++; $display("FAIL starve_grant_count got=%0d exp=10", grants); end
      idle_inputs();
      bus.in_res_ready = 1'b1;
      for (int k = 0; k < 20 && bus.out_busy !== 1'b0; k++) cyc();
      total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL starve_drain busy=%0b exp=0", bus.out_busy); end
   endtask

   task automatic test_simultaneous();
      idle_inputs();
      bus.in_res_ready  = 1'b1;
      total++; if (bus.dbg_wr_streak !== 8'd0) begin bad++; $display("FAIL simul_streak_start got=%0d exp=0", bus.dbg_wr_streak); end
      bus.in_wr_valid   = 1'b1;
      bus.in_srch_valid = 1'b1;
      bus.in_srch_key   = 28'h0777777;
      #1;
      total++; if (bus.out_wr_ready !== 1'b1 || bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL simul_write_wins wr=%0b srch=%0b exp 1 0", bus.out_wr_ready, bus.out_srch_ready); end
      cyc();
      bus.in_wr_valid = 1'b0;
      total++; if (bus.out_srch_ready !== 1'b0) begin bad++; $display("FAIL simul_no_grant_in_write got=%0b exp=0", bus.out_srch_ready); end
      cyc();
      total++; if (bus.out_srch_ready !== 1'b1 || bus.dbg_wr_streak !== 8'd1) begin bad++; $display("FAIL simul_search_next srch=%0b streak=%0d exp 1 1", bus.out_srch_ready, bus.dbg_wr_streak); end
      cyc();
      bus.in_srch_valid = 1'b0;
      for (int k = 0; k < 20 && bus.out_busy !== 1'b0; k++) cyc();
      bus.in_srch_valid = 1'b1;
      bus.in_srch_key   = 28'h0222222;
      #1;
      total++; if (bus.out_srch_ready !== 1'b1 || bus.out_wr_ready !== 1'b0) begin bad++; $display("FAIL simul_search_alone srch=%0b wr=%0b exp 1 0", bus.out_srch_ready, bus.out_wr_ready); end
      cyc();
      bus.in_srch_valid = 1'b0;
      for (int k = 0; k < 20 && bus.out_busy !== 1'b0; k++) cyc();
      total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL simul_drain busy=%0b exp=0", bus.out_busy); end
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      bus.in_res_ready  = 1'b1;
      bus.in_srch_valid = 1'b1;
      bus.in_srch_key   = KEY_W'($urandom);
      cyc();
      bus.in_srch_valid = 1'b0;
      cyc();
      total++; if (bus.dbg_state !== S_WAIT) begin bad++; $display("FAIL rst_reach_wait state=%0d exp=%0d", bus.dbg_state, S_WAIT); end
      #2;
      in_rstn = 1'b0;
      #1;
      total++; if (bus.dbg_state !== S_IDLE || bus.out_mem_csb !== 1'b1 || bus.out_res_valid !== 1'b0 || bus.out_busy !== 1'b0) begin bad++; $display("FAIL rst_async state=%0d csb=%0b valid=%0b busy=%0b exp 0 1 0 0", bus.dbg_state, bus.out_mem_csb, bus.out_res_valid, bus.out_busy); end
      repeat (2) cyc();
      in_rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         total++; if (bus.out_res_valid !== 1'b0 || bus.out_busy !== 1'b0) begin bad++; $display("FAIL rst_no_result cycle=%0d valid=%0b busy=%0b exp 0 0", k, bus.out_res_valid, bus.out_busy); end
      end
   endtask

   // Reference: each grant books a fixed number of busy cycles; searches then hold a result
   // until it is taken. The write streak counts writes granted over a waiting search.
   task automatic test_random();
      logic [PMA_W-1:0]   exp_q [$];
      int                 m_busy, m_streak;
      bit                 m_to_resp, m_resp, m_strobe, m_strobe_wr, m_idle, e_wr, e_srch, drain;
      logic [KEY_W-1:0]   m_addr;
      logic [WMASK_W-1:0] m_wmask;
      logic [DATA_W-1:0]  m_wdata;
      m_busy = 0; m_streak = 0; m_to_resp = 0; m_resp = 0; m_strobe = 0; m_strobe_wr = 0;
      m_addr = '0; m_wmask = '0; m_wdata = '0;
      idle_inputs();
      for (int n = 0; n < 1500; n++) begin
         drain = (n >= 1470);
         total++; if (bus.out_mem_csb !== !m_strobe) begin bad++; $display("FAIL rnd_csb cycle=%0d got=%0b exp=%0b", n, bus.out_mem_csb, !m_strobe); end
         if (m_strobe) begin
            total++; if (bus.out_mem_web !== !m_strobe_wr || bus.out_mem_addr !== m_addr || bus.out_mem_wmask !== m_wmask || bus.out_mem_wdata !== m_wdata) begin bad++; $display("FAIL rnd_strobe cycle=%0d web=%0b addr=%0h wmask=%0h wdata=%0h exp %0b %0h %0h %0h", n, bus.out_mem_web, bus.out_mem_addr, bus.out_mem_wmask, bus.out_mem_wdata, !m_strobe_wr, m_addr, m_wmask, m_wdata); end
         end else begin
            total++; if (bus.out_mem_web !== 1'b1 || bus.out_mem_wmask !== '0) begin bad++; $display("FAIL rnd_quiet cycle=%0d web=%0b wmask=%0h exp 1 0", n, bus.out_mem_web, bus.out_mem_wmask); end
         end
         total++; if (bus.out_busy !== !(m_busy == 0 && !m_resp)) begin bad++; $display("FAIL rnd_busy cycle=%0d got=%0b exp=%0b", n, bus.out_busy, !(m_busy == 0 && !m_resp)); end
         total++; if (bus.out_res_valid !== m_resp) begin bad++; $display("FAIL rnd_res_valid cycle=%0d got=%0b exp=%0b", n, bus.out_res_valid, m_resp); end
         if (m_resp && exp_q.size() > 0) begin
            total++; if (bus.out_res_pma !== exp_q[0]) begin bad++; $display("FAIL rnd_res_pma cycle=%0d got=%0d exp=%0d", n, bus.out_res_pma, exp_q[0]); end
         end
         total++; if (bus.dbg_wr_streak !== 8'(m_streak)) begin bad++; $display("FAIL rnd_streak cycle=%0d got=%0d exp=%0d", n, bus.dbg_wr_streak, m_streak); end

         bus.in_wr_valid   = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
         bus.in_srch_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
         bus.in_res_ready  = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         bus.in_wr_addr    = WR_ADDR_W'($urandom);
         bus.in_wr_wmask   = WMASK_W'($urandom);
         bus.in_wr_wdata   = $urandom;
         bus.in_srch_key   = KEY_W'($urandom);
         #1;
         m_idle = (m_busy == 0) && !m_resp;
         e_wr   = m_idle && bus.in_wr_valid && (!bus.in_srch_valid || m_streak < MAX_WR_BURST);
         e_srch = m_idle && bus.in_srch_valid && !e_wr;
         total++; if (bus.out_wr_ready !== e_wr || bus.out_srch_ready !== e_srch) begin bad++; $display("FAIL rnd_ready cycle=%0d wr=%0b srch=%0b exp %0b %0b", n, bus.out_wr_ready, bus.out_srch_ready, e_wr, e_srch); end

         @(posedge in_clk);
         m_strobe = 1'b0;
         if (m_resp) begin
            if (bus.in_res_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               m_resp = 1'b0;
            end
         end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_to_resp) m_resp = 1'b1;
         end else if (e_wr) begin
            m_strobe = 1'b1; m_strobe_wr = 1'b1;
            m_addr = KEY_W'(bus.in_wr_addr); m_wmask = bus.in_wr_wmask; m_wdata = bus.in_wr_wdata;
            m_busy = 1; m_to_resp = 1'b0;
            if (bus.in_srch_valid && m_streak < MAX_WR_BURST) m_streak++;
         end else if (e_srch) begin
            m_strobe = 1'b1; m_strobe_wr = 1'b0;
            m_addr = bus.in_srch_key; m_wmask = '0; m_wdata = '0;
            m_busy = 1 + RD_LAT; m_to_resp = 1'b1; m_streak = 0;
            exp_q.push_back(pma_of(bus.in_srch_key));
         end
         #1;
      end
      total++; if (exp_q.size() != 0 || bus.out_busy !== 1'b0) begin bad++; $display("FAIL rnd_end pending=%0d busy=%0b exp 0 0", exp_q.size(), bus.out_busy); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_search();
      test_backpressure();
      test_starvation();
      test_simultaneous();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
